// File: rtl/encoder_sample_ctrl.sv
// Encoder sample sequencer: periodic snapshot of speed/step into a FIFO,
// optional clear pulse to the encoder core, Avalon-MM register access and irq.
module encoder_sample_ctrl #(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned DEFAULT_PERIOD = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_write_data,
  input  logic        avs_read,
  output logic [31:0] avs_read_data,
  input  logic [31:0] speed,
  input  logic [31:0] step,
  output logic        clear,
  output logic        irq
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = AW + 1;
  localparam int unsigned DW = 32;

  localparam logic [7:0] ADDR_CTRL       = 8'h00;
  localparam logic [7:0] ADDR_PERIOD     = 8'h01;
  localparam logic [7:0] ADDR_STATUS     = 8'h02;
  localparam logic [7:0] ADDR_WMARK      = 8'h03;
  localparam logic [7:0] ADDR_HEAD_SPEED = 8'h04;
  localparam logic [7:0] ADDR_HEAD_STEP  = 8'h05;

  typedef struct packed {
    logic [DW-1:0] speed;
    logic [DW-1:0] step;
  } sample_t;

  typedef enum logic [1:0] {IDLE, COUNT, CAPTURE, CLEAR} state_t;

  state_t        state, state_d;
  logic [DW-1:0] cnt, cnt_d;
  logic          push_c, clear_d;

  logic          ctrl_enable, ctrl_auto_clear, ctrl_irq_en;
  logic [DW-1:0] period;
  logic [6:0]    wmark;
  logic          ovf;

  sample_t       mem [FIFO_DEPTH];
  logic [LW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_c;
  logic [6:0]    level7_c;
  logic          full_c, empty_c, pop_c, accept_c;
  sample_t       head_c;

  logic          wr_ctrl_c, wr_period_c, wr_status_c, wr_wmark_c, soft_clear_c;
  logic [DW-1:0] rd_mux_c;

  // FIFO occupancy and bus decode
  always_comb begin
    level_c      = wr_ptr - rd_ptr;
    level7_c     = 7'(level_c);
    full_c       = (level_c == LW'(FIFO_DEPTH));
    empty_c      = (level_c == '0);
    head_c       = mem[rd_ptr[AW-1:0]];
    pop_c        = avs_read && (avs_address == ADDR_HEAD_STEP) && !empty_c;
    accept_c     = push_c && (!full_c || pop_c);
    wr_ctrl_c    = avs_write && (avs_address == ADDR_CTRL);
    wr_period_c  = avs_write && (avs_address == ADDR_PERIOD);
    wr_status_c  = avs_write && (avs_address == ADDR_STATUS);
    wr_wmark_c   = avs_write && (avs_address == ADDR_WMARK);
    soft_clear_c = wr_ctrl_c && avs_write_data[2];
  end

  // Sequencer next state; CLEAR cycle counts toward the sample period
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    push_c  = 1'b0;
    clear_d = 1'b0;
    if (!ctrl_enable) begin
      state_d = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          state_d = COUNT;
          cnt_d   = period - 32'd1;
        end
        COUNT: begin
          if (cnt == '0) state_d = CAPTURE;
          else           cnt_d   = cnt - 32'd1;
        end
        CAPTURE: begin
          push_c  = 1'b1;
          cnt_d   = period - 32'd2;
          state_d = ctrl_auto_clear ? CLEAR : COUNT;
        end
        CLEAR: begin
          if (cnt == '0) begin
            state_d = CAPTURE;
          end else begin
            cnt_d   = cnt - 32'd1;
            state_d = COUNT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // A soft clear landing while CLEAR already drives the pulse is absorbed
    clear_d = (state_d == CLEAR) || (soft_clear_c && (state != CLEAR));
  end

  // Register read mux (pre-write values)
  always_comb begin
    rd_mux_c = '0;
    unique case (avs_address)
      ADDR_CTRL:       rd_mux_c = 32'({ctrl_irq_en, 1'b0, ctrl_auto_clear, ctrl_enable});
      ADDR_PERIOD:     rd_mux_c = period;
      ADDR_STATUS:     rd_mux_c = 32'({irq, ovf, 1'b0, level7_c});
      ADDR_WMARK:      rd_mux_c = 32'(wmark);
      ADDR_HEAD_SPEED: rd_mux_c = empty_c ? '0 : head_c.speed;
      ADDR_HEAD_STEP:  rd_mux_c = empty_c ? '0 : head_c.step;
      default:         rd_mux_c = '0;
    endcase
  end

  // FIFO storage; contents are invalidated by pointer reset only
  always_ff @(posedge clk) begin
    if (accept_c) mem[wr_ptr[AW-1:0]] <= '{speed: speed, step: step};
  end

  // Control/status registers, FSM state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      clear           <= 1'b0;
      irq             <= 1'b0;
      avs_read_data   <= '0;
      ctrl_enable     <= 1'b0;
      ctrl_auto_clear <= 1'b0;
      ctrl_irq_en     <= 1'b0;
      period          <= DW'(DEFAULT_PERIOD);
      wmark           <= '0;
      ovf             <= 1'b0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      clear         <= clear_d;
      avs_read_data <= avs_read ? rd_mux_c : '0;
      irq           <= ctrl_irq_en && (ovf || ((wmark != '0) && (level7_c >= wmark)));
      if (wr_ctrl_c) begin
        ctrl_enable     <= avs_write_data[0];
        ctrl_auto_clear <= avs_write_data[1];
        ctrl_irq_en     <= avs_write_data[3];
      end
      if (wr_period_c) period <= (avs_write_data < 32'd2) ? 32'd2 : avs_write_data;
      if (wr_wmark_c)  wmark  <= avs_write_data[6:0];
      if (push_c && full_c && !pop_c)           ovf <= 1'b1;
      else if (wr_status_c && avs_write_data[8]) ovf <= 1'b0;
      if (accept_c) wr_ptr <= wr_ptr + LW'(1);
      if (pop_c)    rd_ptr <= rd_ptr + LW'(1);
    end
  end

endmodule
